// File: rtl/trs80_uart_tx.sv
// Transmit half of a TR1602-style UART: holding register, control register
// snapshot per frame, and a 16x-oversampled shifter driving a registered line.
module trs80_uart_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       thrl,
  input  logic       crl,
  input  logic       pi,
  input  logic       sbs,
  input  logic [1:0] wls,
  input  logic       epe,
  output logic       thre,
  output logic       tre,
  output logic       tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  typedef struct packed {
    logic       pi;
    logic       sbs;
    logic [1:0] wls;
    logic       epe;
  } ctrl_t;

  localparam ctrl_t CTRL_8N1 = '{pi: 1'b1, sbs: 1'b0, wls: 2'b11, epe: 1'b0};

  ctrl_t      ctrl_q;
  ctrl_t      frame_q;
  logic [7:0] thr_q;
  logic [7:0] shift_q;
  logic [3:0] tick_q;
  logic [2:0] bit_q;
  logic       par_q;
  state_t     state_q;
  state_t     state_d;
  logic       tx_d;

  logic       last_tick;
  logic       last_data;
  logic       last_stop;
  logic       load;
  logic [7:0] data_mask;

  assign last_tick = clk_en && (tick_q == 4'd15);
  assign last_data = bit_q == ({1'b0, frame_q.wls} + 3'd4);
  assign last_stop = last_tick &&
                     (((state_q == STOP1) && !frame_q.sbs) || (state_q == STOP2));
  // A pending byte starts either from idle or back-to-back on the final stop pulse.
  assign load      = clk_en && !thre && ((state_q == IDLE) || last_stop);
  assign data_mask = 8'hFF >> (2'd3 - ctrl_q.wls);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = START;
      START:   if (last_tick) state_d = DATA;
      DATA:    if (last_tick && last_data) state_d = frame_q.pi ? STOP1 : PARITY;
      PARITY:  if (last_tick) state_d = STOP1;
      STOP1:   if (last_tick) state_d = frame_q.sbs ? STOP2 : (load ? START : IDLE);
      STOP2:   if (last_tick) state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line value for the state being entered; the shifter moves on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ((state_q == DATA) && last_tick) ? shift_q[1] : shift_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: the holding and shift registers are plain flops, not memories, so
  // they take a defined reset value like everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= CTRL_8N1;
      frame_q <= CTRL_8N1;
      thr_q   <= 8'h00;
      thre    <= 1'b1;
      shift_q <= 8'h00;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      par_q   <= 1'b0;
      tre     <= 1'b1;
      tx      <= 1'b1;
    end else begin
      if (crl) ctrl_q <= '{pi: pi, sbs: sbs, wls: wls, epe: epe};
      if (thrl) thr_q <= din;

      if (thrl)      thre <= 1'b0;
      else if (load) thre <= 1'b1;

      if (load) begin
        frame_q <= ctrl_q;
        shift_q <= thr_q;
        bit_q   <= 3'd0;
        // Parity bit makes the total count of ones even when epe=1, odd otherwise.
        par_q   <= (^(thr_q & data_mask)) ^ ~ctrl_q.epe;
      end else if ((state_q == DATA) && last_tick) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end

      if (clk_en) begin
        tick_q <= ((state_d == IDLE) || last_tick || load) ? 4'd0 : tick_q + 4'd1;
        tx     <= tx_d;
      end

      tre <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_trs80_uart_tx.sv
// Directed bench for trs80_uart_tx: frames are compared bit-time by bit-time
// against hand-computed line sequences (bit i of a vector = i-th bit sent).
module tb_trs80_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en = 1'b0;
  logic [7:0] din;
  logic       thrl, crl, pi, sbs, epe;
  logic [1:0] wls;
  logic       thre, tre, tx;

  int n_checks = 0;
  int n_errs   = 0;
  int en_div   = 1;
  int en_cnt   = 0;

  trs80_uart_tx dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .din(din), .thrl(thrl), .crl(crl),
    .pi(pi), .sbs(sbs), .wls(wls), .epe(epe), .thre(thre), .tre(tre), .tx(tx)
  );

  always #5 clk = ~clk;

  // clk_en: one pulse every en_div cycles, none when en_div is 0.
  always @(negedge clk) begin
    if (en_div == 0) begin
      clk_en = 1'b0;
    end else if (en_cnt >= en_div - 1) begin
      clk_en = 1'b1;
      en_cnt = 0;
    end else begin
      clk_en = 1'b0;
      en_cnt = en_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_ctrl(input logic p, input logic s, input logic [1:0] w, input logic e);
    @(negedge clk);
    crl = 1'b1; pi = p; sbs = s; wls = w; epe = e;
    @(negedge clk);
    crl = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    din = d; thrl = 1'b1;
    @(negedge clk);
    thrl = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k = 0;
    while (tx !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start"}, tx, 1'b0);
  endtask

  // Entered on the first negedge of the start bit; returns on the negedge after
  // the last stop-bit pulse. Each bit is sampled on its first and last cycle.
  task automatic check_frame(input string tag, input logic [31:0] bits, input int n, input int len);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < len; c++) begin
        if (c == 0) begin
          check($sformatf("%s_bit%0d_first", tag, i), tx, bits[i]);
          check($sformatf("%s_bit%0d_tre", tag, i), tre, 1'b0);
        end
        if (c == len - 1) check($sformatf("%s_bit%0d_last", tag, i), tx, bits[i]);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tre"}, tre, 1'b1);
    check({tag, "_thre"}, thre, 1'b1);
    check({tag, "_tx"}, tx, 1'b1);
  endtask

  initial begin
    reset = 1'b1; din = 8'h00; thrl = 1'b0; crl = 1'b0;
    pi = 1'b1; sbs = 1'b0; wls = 2'b11; epe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    // 0x55 8N1 with exact load latency
    @(negedge clk);
    din = 8'h55; thrl = 1'b1;
    @(negedge clk);
    thrl = 1'b0;
    check("t55_thre_low", thre, 1'b0);
    check("t55_tx_idle", tx, 1'b1);
    @(negedge clk);
    check("t55_thre_high", thre, 1'b1);
    check("t55_tre_low", tre, 1'b0);
    check_frame("t55", 32'h2AA, 10, 16);
    check_idle("t55_end");

    // 0x41 7E2; a crl mid-frame must not disturb this frame
    set_ctrl(1'b0, 1'b1, 2'b10, 1'b1);
    strobe(8'h41);
    wait_start("t41", 8);
    fork
      check_frame("t41", 32'h682, 11, 16);
      begin
        repeat (50) @(negedge clk);
        crl = 1'b1; pi = 1'b1; sbs = 1'b0; wls = 2'b11; epe = 1'b0;
        @(negedge clk);
        crl = 1'b0;
      end
    join
    check_idle("t41_end");

    // 0x1F 5O2
    set_ctrl(1'b0, 1'b1, 2'b00, 1'b0);
    strobe(8'h1F);
    wait_start("t1f", 8);
    check_frame("t1f", 32'h1BE, 9, 16);
    check_idle("t1f_end");

    // 0xA5 then 0x3C back to back, 8N1
    do_reset();
    strobe(8'hA5);
    wait_start("ta5", 8);
    fork
      check_frame("ta5_3c", 32'h9E34A, 20, 16);
      begin
        repeat (40) @(negedge clk);
        din = 8'h3C; thrl = 1'b1;
        @(negedge clk);
        thrl = 1'b0;
        check("ta5_thre_after_2nd", thre, 1'b0);
        repeat (100) @(negedge clk);
        check("ta5_thre_pending", thre, 1'b0);
      end
    join
    check_idle("ta5_end");

    // Reset mid-frame, coincident with thrl and crl
    strobe(8'hFF);
    wait_start("tff", 8);
    repeat (40) @(negedge clk);
    reset = 1'b1; thrl = 1'b1; din = 8'h77;
    crl = 1'b1; pi = 1'b0; sbs = 1'b1; wls = 2'b00; epe = 1'b1;
    @(negedge clk);
    reset = 1'b0; thrl = 1'b0; crl = 1'b0;
    check_idle("tff_reset");
    repeat (20) @(negedge clk);
    check_idle("tff_quiet");
    strobe(8'h00);
    wait_start("t00", 8);
    check_frame("t00_8n1", 32'h200, 10, 16);
    check_idle("t00_end");

    // Overwrite while clk_en is held off: only the second byte is sent
    en_div = 0;
    repeat (2) @(negedge clk);
    strobe(8'h11);
    strobe(8'h22);
    check("tovr_thre", thre, 1'b0);
    repeat (5) @(negedge clk);
    check("tovr_frozen_tx", tx, 1'b1);
    check("tovr_frozen_tre", tre, 1'b1);
    en_div = 1;
    wait_start("t22", 8);
    check_frame("t22", 32'h244, 10, 16);
    check_idle("t22_end");

    // Slow clk_en: 16 x 273 clocks per bit
    en_div = 273;
    strobe(8'h00);
    wait_start("tslow", 600);
    check_frame("tslow", 32'h200, 10, 16 * 273);
    check_idle("tslow_end");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
